// File: rtl/score_board.sv
// score_board: multi-player goal scorer with per-goal holdoff and match-end detection.
//
// Ports
//   clk        single clock
//   reset      synchronous, active-high
//   start      begin a new match (from IDLE or GAME_OVER)
//   clear      abort to IDLE and zero scores, winner and max_goal
//   goal       per-player level, high while the ball is in that player's gate
//   scores     packed scores, player i at [i*NBITS +: NBITS]
//   goal_pulse one-cycle strobe per accepted goal
//   max_goal   high while in GAME_OVER
//   winner     index of the winning player, valid while max_goal is high
//   state      FSM state: IDLE=0, PLAY=1, HOLDOFF=2, GAME_OVER=3
//
// All outputs come straight from registers.
module score_board #(
  parameter int NUM_PLAYERS    = 2,
  parameter int NBITS          = 4,
  parameter int WIN_SCORE      = 9,
  parameter int HOLDOFF_CYCLES = 16
) (
  input  logic                         clk,
  input  logic                         reset,
  input  logic                         start,
  input  logic                         clear,
  input  logic [NUM_PLAYERS-1:0]       goal,
  output logic [NUM_PLAYERS*NBITS-1:0] scores,
  output logic [NUM_PLAYERS-1:0]       goal_pulse,
  output logic                         max_goal,
  output logic [2:0]                   winner,
  output logic [1:0]                   state
);

  localparam int CW = (HOLDOFF_CYCLES > 1) ? $clog2(HOLDOFF_CYCLES) : 1;

  generate
    if (NUM_PLAYERS < 2 || NUM_PLAYERS > 8)
      $fatal(1, "score_board: NUM_PLAYERS must be in 2..8");
    if (WIN_SCORE == 0 || WIN_SCORE > (2**NBITS) - 1)
      $fatal(1, "score_board: WIN_SCORE must be in 1..2^NBITS-1");
    if (HOLDOFF_CYCLES < 1)
      $fatal(1, "score_board: HOLDOFF_CYCLES must be >= 1");
  endgenerate

  typedef enum logic [1:0] {
    IDLE      = 2'd0,
    PLAY      = 2'd1,
    HOLDOFF   = 2'd2,
    GAME_OVER = 2'd3
  } state_t;

  state_t                  state_q, state_d;
  logic [NBITS-1:0]        score_q [NUM_PLAYERS];
  logic [NBITS-1:0]        score_d [NUM_PLAYERS];
  logic [NUM_PLAYERS-1:0]  pulse_q, pulse_d;
  logic [NUM_PLAYERS-1:0]  hist_q;
  logic                    max_q, max_d;
  logic [2:0]              win_q, win_d;
  logic [CW-1:0]           cnt_q, cnt_d;
  logic [NUM_PLAYERS-1:0]  rise;
  logic                    found;

  assign rise = goal & ~hist_q;

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q <= IDLE;
      pulse_q <= '0;
      max_q   <= 1'b0;
      win_q   <= '0;
      cnt_q   <= '0;
      // All ones so a goal held through reset is not seen as an edge.
      hist_q  <= '1;
      for (int unsigned i = 0; i < NUM_PLAYERS; i++) score_q[i] <= '0;
    end else begin
      state_q <= state_d;
      pulse_q <= pulse_d;
      max_q   <= max_d;
      win_q   <= win_d;
      cnt_q   <= cnt_d;
      hist_q  <= goal;
      for (int unsigned i = 0; i < NUM_PLAYERS; i++) score_q[i] <= score_d[i];
    end
  end

  always_comb begin
    state_d = state_q;
    pulse_d = '0;
    max_d   = max_q;
    win_d   = win_q;
    cnt_d   = cnt_q;
    found   = 1'b0;
    for (int unsigned i = 0; i < NUM_PLAYERS; i++) score_d[i] = score_q[i];

    if (clear) begin
      state_d = IDLE;
      max_d   = 1'b0;
      win_d   = '0;
      cnt_d   = '0;
      for (int unsigned i = 0; i < NUM_PLAYERS; i++) score_d[i] = '0;
    end else begin
      unique case (state_q)
        IDLE: begin
          for (int unsigned i = 0; i < NUM_PLAYERS; i++) score_d[i] = '0;
          if (start) state_d = PLAY;
        end
        PLAY: begin
          // Ascending scan with a found flag gives lowest-index priority;
          // other simultaneous edges are simply dropped.
          for (int unsigned i = 0; i < NUM_PLAYERS; i++) begin
            if (rise[i] && !found && score_q[i] < NBITS'(WIN_SCORE)) begin
              found      = 1'b1;
              score_d[i] = score_q[i] + 1'b1;
              pulse_d[i] = 1'b1;
              if (score_q[i] + 1'b1 == NBITS'(WIN_SCORE)) begin
                state_d = GAME_OVER;
                max_d   = 1'b1;
                win_d   = 3'(i);
              end else begin
                state_d = HOLDOFF;
                cnt_d   = CW'(HOLDOFF_CYCLES - 1);
              end
            end
          end
        end
        HOLDOFF: begin
          if (cnt_q != '0)       cnt_d   = cnt_q - 1'b1;
          else if (goal == '0)   state_d = PLAY;
        end
        GAME_OVER: begin
          if (start) begin
            state_d = PLAY;
            max_d   = 1'b0;
            win_d   = '0;
            for (int unsigned i = 0; i < NUM_PLAYERS; i++) score_d[i] = '0;
          end
        end
        default: state_d = IDLE;
      endcase
    end
  end

  always_comb begin
    scores = '0;
    for (int unsigned i = 0; i < NUM_PLAYERS; i++) scores[i*NBITS +: NBITS] = score_q[i];
  end

  assign goal_pulse = pulse_q;
  assign max_goal   = max_q;
  assign winner     = win_q;
  assign state      = state_q;

endmodule

// File: tb/tb_score_board.sv
// Directed testbench for score_board with default parameters
// (2 players, 4-bit scores, WIN_SCORE 9, HOLDOFF_CYCLES 16).
module tb_score_board;

  logic       clk = 1'b0;
  logic       reset, start, clear;
  logic [1:0] goal;
  logic [7:0] scores;
  logic [1:0] goal_pulse;
  logic       max_goal;
  logic [2:0] winner;
  logic [1:0] state;

  int tests  = 0;
  int failed = 0;
  int pulses;

  score_board #(
    .NUM_PLAYERS(2),
    .NBITS(4),
    .WIN_SCORE(9),
    .HOLDOFF_CYCLES(16)
  ) dut (
    .clk(clk),
    .reset(reset),
    .start(start),
    .clear(clear),
    .goal(goal),
    .scores(scores),
    .goal_pulse(goal_pulse),
    .max_goal(max_goal),
    .winner(winner),
    .state(state)
  );

  always #5 clk = ~clk;

  // Advance one clock; inputs are driven and outputs sampled 1 time unit after the edge.
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    tests++;
    assert (obs === exp) else begin
      failed++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic wait_play(input string tag);
    for (int i = 0; i < 40 && state !== 2'd1; i++) tick();
    chk(tag, 32'(state), 32'd1);
  endtask

  initial begin
    reset = 1'b1; start = 1'b0; clear = 1'b0; goal = 2'b00;
    tick(); tick();
    reset = 1'b0;
    chk("rst_state",  32'(state), 32'd0);
    chk("rst_scores", 32'(scores), 32'h00);
    chk("rst_pulse",  32'(goal_pulse), 32'd0);
    chk("rst_max",    32'(max_goal), 32'd0);
    chk("rst_winner", 32'(winner), 32'd0);

    // Goals ignored in IDLE
    goal = 2'b01; tick(); goal = 2'b00; tick();
    chk("idle_scores", 32'(scores), 32'h00);
    chk("idle_state",  32'(state), 32'd0);

    // Single goal, holdoff timing
    start = 1'b1; tick(); start = 1'b0;
    chk("start_play", 32'(state), 32'd1);
    goal = 2'b01; tick(); goal = 2'b00;
    chk("g0_scores", 32'(scores), 32'h01);
    chk("g0_pulse",  32'(goal_pulse), 32'd1);
    chk("g0_state",  32'(state), 32'd2);
    start = 1'b1; tick(); start = 1'b0;
    chk("g0_pulse_off", 32'(goal_pulse), 32'd0);
    chk("start_ign_holdoff", 32'(state), 32'd2);
    repeat (14) tick();
    chk("holdoff_e15", 32'(state), 32'd2);
    tick();
    chk("holdoff_e16_play", 32'(state), 32'd1);

    // Simultaneous edges: lowest index wins
    goal = 2'b11; tick(); goal = 2'b00;
    chk("sim_scores", 32'(scores), 32'h02);
    chk("sim_pulse",  32'(goal_pulse), 32'd1);
    wait_play("sim_play");

    // Held goal: one increment, stay in HOLDOFF until released
    goal = 2'b10; tick();
    chk("hold_scores", 32'(scores), 32'h12);
    chk("hold_pulse",  32'(goal_pulse), 32'd2);
    pulses = 0;
    for (int i = 0; i < 39; i++) begin
      tick();
      if (goal_pulse != 2'b00) pulses++;
    end
    chk("hold_no_more_pulses", 32'(pulses), 32'd0);
    chk("hold_state",  32'(state), 32'd2);
    chk("hold_scores2", 32'(scores), 32'h12);
    goal = 2'b00; tick();
    chk("hold_release_play", 32'(state), 32'd1);

    // Score player 1 to 9
    for (int k = 0; k < 7; k++) begin
      goal = 2'b10; tick(); goal = 2'b00; tick();
      wait_play("win_play");
    end
    chk("pre_win_scores", 32'(scores), 32'h82);
    goal = 2'b10; tick(); goal = 2'b00;
    chk("win_scores", 32'(scores), 32'h92);
    chk("win_pulse",  32'(goal_pulse), 32'd2);
    chk("win_max",    32'(max_goal), 32'd1);
    chk("win_winner", 32'(winner), 32'd1);
    chk("win_state",  32'(state), 32'd3);
    tick();
    goal = 2'b11; tick(); goal = 2'b00; tick();
    chk("go_frozen_scores", 32'(scores), 32'h92);
    chk("go_frozen_state",  32'(state), 32'd3);
    chk("go_frozen_winner", 32'(winner), 32'd1);
    start = 1'b1; tick(); start = 1'b0;
    chk("restart_scores", 32'(scores), 32'h00);
    chk("restart_max",    32'(max_goal), 32'd0);
    chk("restart_winner", 32'(winner), 32'd0);
    chk("restart_state",  32'(state), 32'd1);

    // Clear + start in HOLDOFF with score0 = 3
    for (int k = 0; k < 2; k++) begin
      goal = 2'b01; tick(); goal = 2'b00; tick();
      wait_play("clr_play");
    end
    goal = 2'b01; tick(); goal = 2'b00;
    chk("clr_pre_scores", 32'(scores), 32'h03);
    chk("clr_pre_state",  32'(state), 32'd2);
    clear = 1'b1; start = 1'b1; tick(); clear = 1'b0; start = 1'b0;
    chk("clr_state",  32'(state), 32'd0);
    chk("clr_scores", 32'(scores), 32'h00);

    // Goal held through reset is not an edge
    goal = 2'b01; reset = 1'b1; tick(); tick(); reset = 1'b0;
    start = 1'b1; tick(); start = 1'b0;
    chk("rh_state", 32'(state), 32'd1);
    tick(); tick(); tick();
    chk("rh_scores", 32'(scores), 32'h00);
    chk("rh_pulse",  32'(goal_pulse), 32'd0);
    goal = 2'b00; tick();
    goal = 2'b01; tick();
    chk("rh_edge_scores", 32'(scores), 32'h01);
    chk("rh_edge_pulse",  32'(goal_pulse), 32'd1);

    // Reset mid-HOLDOFF
    goal = 2'b00; tick();
    chk("mid_holdoff", 32'(state), 32'd2);
    reset = 1'b1; tick(); reset = 1'b0;
    chk("rst_mid_state",  32'(state), 32'd0);
    chk("rst_mid_scores", 32'(scores), 32'h00);
    chk("rst_mid_pulse",  32'(goal_pulse), 32'd0);

    $display("[TB] %0d tests run, %0d failed", tests, failed);
    $finish;
  end

endmodule
